// File: rtl/read_dma_feeder.sv
// read_dma_feeder: takes one fill request at a time and splits it into
// line-sized global reads, keeping at most MAX_OUT reads in flight. In-order
// read responses come back out as SRAM write beats, and a done pulse marks the
// end of each fill.
module read_dma_feeder #(
  parameter int GBW     = 32,
  parameter int HBW     = 10,
  parameter int DBW     = 16,
  parameter int VSIZE   = 32,
  parameter int LCNT_BW = 8,
  parameter int MAX_OUT = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_rp_en_rdy,
  output logic                   o_rp_en_ack,
  input  logic [GBW-1:0]         i_gaddr,
  input  logic [HBW-1:0]         i_lhiaddr,
  input  logic [LCNT_BW-1:0]     i_nline,
  output logic                   o_mreq_rdy,
  input  logic                   i_mreq_ack,
  output logic [GBW-1:0]         o_mreq_addr,
  input  logic                   i_mresp_dval,
  input  logic [VSIZE*DBW-1:0]   i_mresp_data,
  output logic                   o_dma_write_dval,
  output logic [HBW-1:0]         o_dma_whiaddr,
  output logic [VSIZE*DBW-1:0]   o_dma_wdata,
  output logic                   o_done_dval,
  output logic                   o_err
);

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int LW = VSIZE * DBW;
  localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUT);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e               state_q, state_d;
  logic [GBW-1:0]       req_addr_q, req_addr_d;
  logic [HBW-1:0]       wr_addr_q, wr_addr_d;
  logic [LCNT_BW-1:0]   req_left_q, req_left_d;
  logic [LCNT_BW-1:0]   resp_left_q, resp_left_d;
  logic [OW-1:0]        outst_q, outst_d;
  logic                 wbeat_q;
  logic [HBW-1:0]       whiaddr_q;
  logic [LW-1:0]        wdata_q;
  logic                 done_q;
  logic                 err_q;

  logic                 rp_ack;
  logic                 mreq_rdy;
  logic                 mreq_fire;
  logic                 resp_acc;

  // A response is taken only while a fill is active and a read is in flight.
  // Anything else is a stray response: it is dropped and flagged.
  assign mreq_fire = mreq_rdy & i_mreq_ack;
  assign resp_acc  = i_mresp_dval && (outst_q != '0) &&
                     ((state_q == ISSUE) || (state_q == DRAIN));

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. ISSUE ends on the handshake of the last line. DRAIN ends
  // once every line has been taken in.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rp_ack) state_d = (i_nline == '0) ? DONE : ISSUE;
      ISSUE:   if (mreq_fire && (req_left_q == LCNT_BW'(1))) state_d = DRAIN;
      DRAIN:   if (resp_left_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs. mreq_rdy depends only on registered state, so once it
  // is raised it stays up until the ack. Without an ack, outstanding can only
  // go down and req_left cannot change.
  always_comb begin
    rp_ack   = 1'b0;
    mreq_rdy = 1'b0;
    case (state_q)
      IDLE:    rp_ack   = i_rp_en_rdy;
      ISSUE:   mreq_rdy = (req_left_q != '0) && (outst_q < MAX_OUT_C);
      default: ;
    endcase
  end

  // Next values for the address, line and outstanding counters. The write
  // address advances when a response is taken, so the next response in line
  // already sees the following line address.
  always_comb begin
    req_addr_d  = req_addr_q;
    wr_addr_d   = wr_addr_q;
    req_left_d  = req_left_q;
    resp_left_d = resp_left_q;
    outst_d     = outst_q;
    if (rp_ack) begin
      req_addr_d  = i_gaddr;
      wr_addr_d   = i_lhiaddr;
      req_left_d  = i_nline;
      resp_left_d = i_nline;
    end
    if (mreq_fire) begin
      req_addr_d = req_addr_q + GBW'(1);
      req_left_d = req_left_q - LCNT_BW'(1);
    end
    if (resp_acc) begin
      wr_addr_d   = wr_addr_q + HBW'(1);
      resp_left_d = resp_left_q - LCNT_BW'(1);
    end
    case ({mreq_fire, resp_acc})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: ;
    endcase
  end

  // Counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      req_addr_q  <= '0;
      wr_addr_q   <= '0;
      req_left_q  <= '0;
      resp_left_q <= '0;
      outst_q     <= '0;
    end else begin
      req_addr_q  <= req_addr_d;
      wr_addr_q   <= wr_addr_d;
      req_left_q  <= req_left_d;
      resp_left_q <= resp_left_d;
      outst_q     <= outst_d;
    end
  end

  // Write beat one cycle after each accepted response. Address and data hold
  // between beats. The done pulse comes one cycle after the DONE state, which
  // is always at least one cycle after the last beat. The error bit is sticky.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wbeat_q   <= 1'b0;
      whiaddr_q <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wbeat_q <= resp_acc;
      if (resp_acc) begin
        whiaddr_q <= wr_addr_q;
        wdata_q   <= i_mresp_data;
      end
      done_q <= (state_q == DONE);
      if (i_mresp_dval && !resp_acc) err_q <= 1'b1;
    end
  end

  assign o_rp_en_ack      = rp_ack;
  assign o_mreq_rdy       = mreq_rdy;
  assign o_mreq_addr      = req_addr_q;
  assign o_dma_write_dval = wbeat_q;
  assign o_dma_whiaddr    = whiaddr_q;
  assign o_dma_wdata      = wdata_q;
  assign o_done_dval      = done_q;
  assign o_err            = err_q;

endmodule

// File: tb/tb_read_dma_feeder.sv
// Testbench for read_dma_feeder. The bench acts as the requester and as global
// memory. A reference model expands each accepted fill into its expected read
// addresses and write beats. A negedge monitor checks the DUT against that
// model every cycle.
module tb_read_dma_feeder;
  localparam int GBW = 32, HBW = 10, DBW = 16, VSIZE = 32, LCNT_BW = 8, MAX_OUT = 4;
  localparam int LW = VSIZE * DBW;

  logic clk, i_rst;
  logic i_rp_en_rdy, o_rp_en_ack;
  logic [GBW-1:0] i_gaddr, o_mreq_addr;
  logic [HBW-1:0] i_lhiaddr, o_dma_whiaddr;
  logic [LCNT_BW-1:0] i_nline;
  logic o_mreq_rdy, i_mreq_ack, i_mresp_dval, o_dma_write_dval, o_done_dval, o_err;
  logic [LW-1:0] i_mresp_data, o_dma_wdata;

  read_dma_feeder #(.GBW(GBW), .HBW(HBW), .DBW(DBW), .VSIZE(VSIZE),
                    .LCNT_BW(LCNT_BW), .MAX_OUT(MAX_OUT)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_rp_en_rdy(i_rp_en_rdy), .o_rp_en_ack(o_rp_en_ack),
    .i_gaddr(i_gaddr), .i_lhiaddr(i_lhiaddr), .i_nline(i_nline),
    .o_mreq_rdy(o_mreq_rdy), .i_mreq_ack(i_mreq_ack), .o_mreq_addr(o_mreq_addr),
    .i_mresp_dval(i_mresp_dval), .i_mresp_data(i_mresp_data),
    .o_dma_write_dval(o_dma_write_dval), .o_dma_whiaddr(o_dma_whiaddr),
    .o_dma_wdata(o_dma_wdata), .o_done_dval(o_done_dval), .o_err(o_err)
  );

  typedef struct packed {logic [31:0] addr; int due; logic legit;} rsp_t;

  int checks = 0, errors = 0, cyc = 0;
  int n_ack = 0, n_fire = 0, n_beat = 0, n_done = 0;
  int hold = 0, rel_req = 0, rel_done = 0, inj_req = 0, inj_done = 0;
  int ack_mode = 1, lat_base = 2, lat_jit = 0;
  logic resp_legit;
  rsp_t pend_q[$];
  logic [31:0] exp_ma_q[$];
  logic [31:0] exp_wg_q[$];
  logic [HBW-1:0] exp_wa_q[$];

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end
  initial begin #1_000_000; $display("FAIL watchdog: sim time limit reached"); $fatal(1); end

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory contents: a fixed scramble of the line address.
  function automatic logic [LW-1:0] mem(input logic [31:0] a);
    logic [LW-1:0] d;
    logic [31:0] w;
    d = '0;
    for (int i = 0; i < LW / 32; i++) begin
      w = (a * 32'h9E37_79B1) ^ (32'(i) * 32'h0101_0101) ^ 32'h5A5A_C3C3;
      d[i*32 +: 32] = w;
    end
    return d;
  endfunction

  // Read ack driver: 0 = never, 1 = always, 2 = random.
  initial begin
    i_mreq_ack = 0;
    forever begin
      @(posedge clk); #1;
      case (ack_mode)
        0:       i_mreq_ack = 1'b0;
        1:       i_mreq_ack = 1'b1;
        default: i_mreq_ack = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Memory responder: returns responses in order once they are due. It also
  // injects stray responses on request.
  initial begin
    rsp_t r;
    i_mresp_dval = 0; i_mresp_data = '0; resp_legit = 0;
    forever begin
      @(posedge clk); #1;
      i_mresp_dval = 0; resp_legit = 0; i_mresp_data = {16{$urandom()}};
      if (inj_req > inj_done) begin
        inj_done++;
        i_mresp_dval = 1;
      end else if (pend_q.size() > 0 && pend_q[0].due <= cyc && (hold == 0 || rel_req > rel_done)) begin
        if (hold != 0) rel_done++;
        r = pend_q.pop_front();
        i_mresp_dval = 1; i_mresp_data = mem(r.addr); resp_legit = r.legit;
      end
    end
  end

  // Monitor and reference model.
  initial begin
    logic busy, prev_ok, prev_ok_n, err_m, prev_hold, exp_rdy;
    logic [31:0] prev_addr, ea, eg;
    logic [HBW-1:0] ew;
    int out_m, zero_due;
    rsp_t mr;
    busy = 0; prev_ok = 0; err_m = 0; prev_hold = 0; out_m = 0; zero_due = -1; prev_addr = '0;
    forever begin
      @(negedge clk);
      if (i_rst) begin
        for (int i = 0; i < pend_q.size(); i++) begin mr = pend_q[i]; mr.legit = 1'b0; pend_q[i] = mr; end
        exp_ma_q.delete(); exp_wg_q.delete(); exp_wa_q.delete();
        busy = 0; prev_ok = 0; err_m = 0; prev_hold = 0; out_m = 0; zero_due = -1;
        continue;
      end
      exp_rdy = busy && (exp_ma_q.size() > 0) && (out_m < MAX_OUT);
      chk("mreq_rdy", o_mreq_rdy, exp_rdy);
      if (prev_hold) chk("mreq_addr_stable", o_mreq_addr, prev_addr);
      chk("write_dval", o_dma_write_dval, prev_ok);
      if (o_dma_write_dval && prev_ok) begin
        n_beat++;
        if (exp_wa_q.size() == 0) chk("beat_unexpected", 1, 0);
        else begin
          ew = exp_wa_q.pop_front(); eg = exp_wg_q.pop_front();
          chk("whiaddr", o_dma_whiaddr, ew);
          chk("wdata", o_dma_wdata, mem(eg));
        end
      end
      chk("err", o_err, err_m);
      if (zero_due >= 0 && cyc == zero_due) chk("done_nline0_timing", o_done_dval, 1);
      if (o_done_dval) begin
        n_done++;
        chk("done_while_busy", busy, 1);
        chk("done_beats_left", exp_wa_q.size(), 0);
        chk("done_outstanding", out_m, 0);
        chk("done_with_beat", o_dma_write_dval, 0);
        if (zero_due >= 0) chk("done_nline0_cycle", cyc, zero_due);
        zero_due = -1; busy = 0;
      end
      chk("rp_en_ack", o_rp_en_ack, i_rp_en_rdy && !busy);
      if (o_rp_en_ack) begin
        n_ack++; busy = 1;
        for (int k = 0; k < int'(i_nline); k++) begin
          exp_ma_q.push_back(i_gaddr + 32'(k));
          exp_wg_q.push_back(i_gaddr + 32'(k));
          exp_wa_q.push_back(i_lhiaddr + HBW'(k));
        end
        if (i_nline == '0) zero_due = cyc + 2;
      end
      if (o_mreq_rdy && i_mreq_ack) begin
        n_fire++;
        if (exp_ma_q.size() == 0) chk("mreq_unexpected", 1, 0);
        else begin ea = exp_ma_q.pop_front(); chk("mreq_addr", o_mreq_addr, ea); end
        out_m++;
        mr.addr = o_mreq_addr; mr.due = cyc + lat_base + int'($urandom_range(0, lat_jit)); mr.legit = 1'b1;
        pend_q.push_back(mr);
      end
      prev_ok_n = 0;
      if (i_mresp_dval) begin
        if (resp_legit) begin out_m--; prev_ok_n = 1; end
        else err_m = 1;
      end
      prev_ok = prev_ok_n;
      prev_hold = o_mreq_rdy && !i_mreq_ack;
      prev_addr = o_mreq_addr;
    end
  end

  task automatic chk_zero(input string t);
    chk({t, "_ack"}, o_rp_en_ack, 0);
    chk({t, "_mreq_rdy"}, o_mreq_rdy, 0);
    chk({t, "_mreq_addr"}, o_mreq_addr, 0);
    chk({t, "_wdval"}, o_dma_write_dval, 0);
    chk({t, "_whiaddr"}, o_dma_whiaddr, 0);
    chk({t, "_wdata"}, o_dma_wdata, 0);
    chk({t, "_done"}, o_done_dval, 0);
    chk({t, "_err"}, o_err, 0);
  endtask

  task automatic req(input logic [31:0] g, input logic [HBW-1:0] l, input logic [7:0] n);
    int a0, b;
    a0 = n_ack; b = 0;
    @(posedge clk); #1;
    i_rp_en_rdy = 1; i_gaddr = g; i_lhiaddr = l; i_nline = n;
    while (n_ack == a0 && b < 3000) begin @(posedge clk); #1; b++; end
    chk("ack_timeout", n_ack != a0, 1);
    i_rp_en_rdy = 0;
  endtask

  task automatic wait_done(input int target);
    int b;
    b = 0;
    while (n_done < target && b < 3000) begin @(posedge clk); #1; b++; end
    chk("done_timeout", n_done >= target, 1);
  endtask

  task automatic do_fill(input logic [31:0] g, input logic [HBW-1:0] l, input logic [7:0] n);
    int d0, f0, b0;
    d0 = n_done; f0 = n_fire; b0 = n_beat;
    req(g, l, n);
    wait_done(d0 + 1);
    repeat (2) @(posedge clk); #1;
    chk("fill_fires", n_fire - f0, int'(n));
    chk("fill_beats", n_beat - b0, int'(n));
    chk("fill_dones", n_done - d0, 1);
  endtask

  initial begin
    int d0, f0, b0, b;
    i_rst = 1; i_rp_en_rdy = 0; i_gaddr = '0; i_lhiaddr = '0; i_nline = '0;
    repeat (3) @(posedge clk); #2;
    chk_zero("reset");
    @(posedge clk); #1 i_rst = 0;
    repeat (2) @(posedge clk);

    // Basic fill with fixed response latency, then both address wraps, then an empty fill.
    ack_mode = 1; lat_base = 2; lat_jit = 0;
    do_fill(32'h100, 10'd5, 8'd3);
    do_fill(32'hFFFF_FFFF, 10'd1023, 8'd2);
    do_fill(32'h1234, 10'd7, 8'd0);

    // Outstanding limit: hold all responses, then release them one at a time.
    hold = 1; lat_base = 1;
    d0 = n_done; f0 = n_fire; b0 = n_beat;
    req(32'h2000, 10'd50, 8'd8);
    repeat (20) @(posedge clk); #1;
    chk("bp_fires", n_fire - f0, MAX_OUT);
    chk("bp_rdy_low", o_mreq_rdy, 0);
    rel_req++;
    repeat (10) @(posedge clk); #1;
    chk("bp_fire_after_release", n_fire - f0, MAX_OUT + 1);
    chk("bp_beats_after_release", n_beat - b0, 1);
    hold = 0;
    wait_done(d0 + 1);
    repeat (2) @(posedge clk); #1;
    chk("bp_total_beats", n_beat - b0, 8);

    // A second request raised while the first fill is still running.
    ack_mode = 2; lat_base = 3; lat_jit = 2;
    d0 = n_done;
    req(32'h4000, 10'd100, 8'd6);
    req(32'h5000, 10'd200, 8'd3);
    wait_done(d0 + 2);

    // Random fills.
    for (int i = 0; i < 25; i++) begin
      ack_mode = int'($urandom_range(1, 2));
      lat_base = int'($urandom_range(1, 3));
      lat_jit  = int'($urandom_range(0, 3));
      do_fill($urandom(), HBW'($urandom_range(1010, 1033)), 8'($urandom_range(0, 12)));
    end

    // Stray response while idle sets the sticky error bit.
    repeat (3) @(posedge clk);
    inj_req++;
    repeat (3) @(posedge clk); #1;
    chk("err_after_stray", o_err, 1);
    ack_mode = 1; lat_base = 1; lat_jit = 1;
    do_fill(32'h7000, 10'd10, 8'd3);
    chk("err_still_set", o_err, 1);

    // Reset in the middle of ISSUE. Responses still in flight afterwards set the error bit.
    hold = 1; ack_mode = 1; lat_base = 1; lat_jit = 0;
    f0 = n_fire;
    req(32'h8000, 10'd300, 8'd8);
    b = 0;
    while (n_fire - f0 < 2 && b < 100) begin @(posedge clk); #1; b++; end
    chk("mid_rdy_before_reset", o_mreq_rdy, 1);
    #2 i_rst = 1;
    #1 chk_zero("reset_mid");
    repeat (3) @(posedge clk);
    #1 i_rst = 0;
    #2 hold = 0;
    b = 0;
    while (pend_q.size() > 0 && b < 100) begin @(posedge clk); #1; b++; end
    repeat (3) @(posedge clk); #1;
    chk("err_stale_resp", o_err, 1);
    do_fill(32'h9000, 10'd0, 8'd4);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
